sc_et_accum: RTL
================

SC_ET_ACCUM -- requirements
Module: sc_et_accum

Interface
REQ-001 Parameter: W, default 8, log2 of maximum stream length; legal range 1..15.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high; clears all state.
REQ-004 Port: start  input  1  request a new conversion; accepted only in IDLE.
REQ-005 Port: prec  input  4  requested precision k; terminate after 2^k stream bits; sampled on accepted start.
REQ-006 Port: z  input  1  stochastic bitstream bit from the upstream SC datapath (e.g. mac/rced output).
REQ-007 Port: z_valid  input  1  z carries a valid bit this cycle.
REQ-008 Port: z_ready  output  1  block consumes z this cycle; high exactly in RUN.
REQ-009 Port: out_valid  output  1  result available; high exactly in DONE.
REQ-010 Port: out_ready  input  1  downstream accepts result.
REQ-011 Port: out_val  output  W  unipolar value estimate, scaled to W fractional bits.
REQ-012 Port: out_len  output  W+1  number of stream bits consumed for this result.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE -> RUN on start=1; this edge latches k = min(prec, W), clears ones-count cnt and length len.
REQ-015 start in RUN or DONE SHALL be ignored, including start coincident with out_ready in DONE.
REQ-016 In RUN, each cycle with z_valid=1 SHALL add z to cnt and 1 to len; cycles with z_valid=0 SHALL change nothing.
REQ-017 RUN -> DONE on the edge that accepts bit number 2^k (len becomes 2^k); no bit beyond 2^k is consumed.
REQ-018 out_valid SHALL rise in the cycle after the accepting edge of the final bit (one-cycle registered latency).
REQ-019 out_val SHALL be all-ones when cnt = 2^k (saturation), else cnt shifted left by (W-k); k=0 gives one bit, out_val 0 or all-ones.
REQ-020 out_len SHALL equal len (2^k) and SHALL hold, with out_val, stable throughout DONE.
REQ-021 DONE -> IDLE on out_ready=1; out_val/out_len SHALL hold their last values in IDLE until the next start.
REQ-022 cnt and len SHALL be W+1 bits wide; no overflow is possible since len never exceeds 2^W.

Reset
REQ-023 rst=1 SHALL asynchronously force IDLE, cnt=0, len=0, z_ready=0, out_valid=0, out_val=0, out_len=0.
REQ-024 rst asserted mid-RUN or mid-DONE SHALL discard the conversion without producing out_valid.
REQ-025 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-026 Macro SC_ET_EN defined: early termination enabled; k = min(prec, W) per REQ-014.
REQ-027 Macro SC_ET_EN undefined: prec ignored, k fixed at W, every conversion consumes 2^W bits; all other behaviour identical.

Verification (W=8)
REQ-028 SC_ET_EN, prec=4, 16 valid bits with 8 ones -> out_val=0x80, out_len=16, out_valid one cycle after 16th accept.
REQ-029 SC_ET_EN, prec=8, 256 ones -> out_val=0xFF (saturated), out_len=256.
REQ-030 SC_ET_EN undefined, prec=2, 256 bits with 64 ones -> out_val=0x40, out_len=256.
REQ-031 prec=3, z_valid toggling 1/0 with z=1 always -> 8 bits counted over 16 cycles, out_val=0xFF, out_len=8.
REQ-032 DONE with out_ready=0 for 5 cycles plus start pulses -> out_valid, out_val, out_len stable; no restart; IDLE after out_ready.
REQ-033 rst after 10 accepted bits -> all outputs 0 immediately, IDLE, z_ready=0; next start runs cleanly from cnt=0.

Source files
------------

// File: rtl/sc_et_accum.sv
// Stochastic bitstream accumulator with optional early termination.
// Define SC_ET_EN to let prec shorten the stream; otherwise 2^W bits are always consumed.
module sc_et_accum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   prec,
  input  logic         z,
  input  logic         z_valid,
  output logic         z_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_val,
  output logic [W:0]   out_len
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] WK = 4'(W);

  logic [1:0] state;
  logic [3:0] k;
  logic [3:0] k_sel;
  logic [W:0] cnt;
  logic [W:0] len;
  logic [W:0] cnt_n;
  logic [W:0] len_n;
  logic [W:0] target;

`ifdef SC_ET_EN
  assign k_sel = (prec > WK) ? WK : prec;
`else
  logic unused_prec;
  assign unused_prec = ^prec;
  assign k_sel = WK;
`endif

  assign cnt_n  = cnt + (W+1)'(z);
  assign len_n  = len + (W+1)'(1);
  assign target = (W+1)'(1) << k;

  assign z_ready   = (state == RUN);
  assign out_valid = (state == DONE);

  // The result is registered on the edge that accepts the last bit, so it is
  // already stable when DONE becomes visible and holds until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      cnt     <= '0;
      len     <= '0;
      out_val <= '0;
      out_len <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            k     <= k_sel;
            cnt   <= '0;
            len   <= '0;
          end
        end
        RUN: begin
          if (z_valid) begin
            cnt <= cnt_n;
            len <= len_n;
            if (len_n == target) begin
              state   <= DONE;
              out_len <= len_n;
              out_val <= (cnt_n == target) ? '1 : W'(cnt_n << (WK - k));
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
